// File: rtl/fdtd_hy_sweep_ctrl.sv
// Sequencer for the Hy update datapath: sweeps N cells issuing Ez/Hy reads,
// tracks in-flight samples through a tagged valid pipe and issues Hy write-backs.
module fdtd_hy_sweep_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1,
  parameter int PIPE_LAT   = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] num_cells,
  output logic                  busy,
  output logic                  done,
  output logic                  clken,
  output logic                  ez_rd_en,
  output logic [ADDR_WIDTH-1:0] ez_rd_addr,
  output logic                  hy_rd_en,
  output logic [ADDR_WIDTH-1:0] hy_rd_addr,
  output logic                  hy_wr_en,
  output logic [ADDR_WIDTH-1:0] hy_wr_addr
);

  localparam int LAT = RD_LAT + PIPE_LAT;
  // All pipe stages except the output stage, whose write completes this cycle.
  localparam logic [LAT-1:0] PEND_MASK = {LAT{1'b1}} >> 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  st_q, st_d;
  logic [ADDR_WIDTH-1:0]   k_q, k_d;
  logic [ADDR_WIDTH-1:0]   n_q, n_d;
  logic                    pipe_clr;
  logic [LAT-1:0]          vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]   tag_q [LAT];
  logic [ADDR_WIDTH-1:0]   tag_d [LAT];

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q  <= IDLE;
      k_q   <= '0;
      n_q   <= '0;
      vld_q <= '0;
    end else begin
      st_q  <= st_d;
      k_q   <= k_d;
      n_q   <= n_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag_q <= tag_d;
  end

  always_comb begin
    st_d     = st_q;
    k_d      = k_q;
    n_d      = n_q;
    pipe_clr = 1'b0;
    case (st_q)
      IDLE: begin
        if (start) begin
          k_d = '0;
          if (num_cells != '0) begin
            n_d  = num_cells;
            st_d = RUN;
          end else begin
            st_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          st_d     = IDLE;
          pipe_clr = 1'b1;
        end else if (k_q == n_q) begin
          st_d = DRAIN;
        end else begin
          k_d = k_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          st_d     = IDLE;
          pipe_clr = 1'b1;
        end else if ((vld_q & PEND_MASK) == '0) begin
          st_d = DONE;
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  assign busy       = (st_q != IDLE);
  assign done       = (st_q == DONE);
  assign clken      = (st_q == RUN) || (st_q == DRAIN);
  assign ez_rd_en   = (st_q == RUN);
  assign ez_rd_addr = ez_rd_en ? k_q : '0;
  // Slot 0 only primes Ez[0]; Hy reads lag the Ez index by one cell.
  assign hy_rd_en   = (st_q == RUN) && (k_q != '0);
  assign hy_rd_addr = hy_rd_en ? (k_q - ADDR_WIDTH'(1)) : '0;
  assign hy_wr_en   = vld_q[LAT-1];
  assign hy_wr_addr = hy_wr_en ? tag_q[LAT-1] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign vld_d[gi] = pipe_clr ? 1'b0 : (clken ? hy_rd_en : vld_q[gi]);
        assign tag_d[gi] = clken ? hy_rd_addr : tag_q[gi];
      end else begin : g_tail
        assign vld_d[gi] = pipe_clr ? 1'b0 : (clken ? vld_q[gi-1] : vld_q[gi]);
        assign tag_d[gi] = clken ? tag_q[gi-1] : tag_q[gi];
      end
    end
  endgenerate

endmodule

// File: doc/fdtd_hy_sweep_ctrl.md
Name: fdtd_hy_sweep_ctrl

Overview:
Sequencer for the Hy update datapath (Hy_n = chyh*Hy_old + chyez*(Ez[i+1]-Ez[i])). On start, it sweeps a 1-D grid of N cells:
- issues Ez and Hy read addresses to field memories;
- drives the datapath clock enable;
- tracks in-flight samples through a valid shift register;
- issues Hy write-back addresses when results emerge.

It sits between the FDTD top-level step sequencer (start/done) and the field RAMs plus Hy datapath.

Parameters:
ADDR_WIDTH, 10, width of cell index and memory addresses.
RD_LAT, 1, field memory read latency in cycles (read data valid RD_LAT cycles after rd_en).
PIPE_LAT, 6, datapath latency in enabled cycles, from first read data at datapath input to Hy_n_o valid.
(Derived) LAT = RD_LAT + PIPE_LAT, default 7.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous active-high reset.
start  in  1  one-cycle request to begin a sweep; ignored while busy.
abort  in  1  cancels the sweep in progress; ignored when idle.
num_cells  in  ADDR_WIDTH  number of Hy cells N; sampled when start is accepted.
busy  out  1  high from the cycle after start is accepted through the done cycle.
done  out  1  one-cycle pulse after the last Hy write.
clken  out  1  datapath CE.
ez_rd_en  out  1  Ez memory read strobe.
ez_rd_addr  out  ADDR_WIDTH  Ez read address.
hy_rd_en  out  1  Hy memory read strobe.
hy_rd_addr  out  ADDR_WIDTH  Hy read address.
hy_wr_en  out  1  Hy write strobe.
hy_wr_addr  out  ADDR_WIDTH  Hy write address; write data is Hy_n_o from the datapath.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, valid pipe cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and N>0: latch N, go to RUN.
  - start=1 and N=0: go directly to DONE; no reads or writes.
- RUN, one slot per cycle, slot counter k = 0..N:
  - slot 0: ez_rd_en=1, ez_rd_addr=0, hy_rd_en=0 (prime).
  - slots 1..N: ez_rd_en=1, ez_rd_addr=k, hy_rd_en=1, hy_rd_addr=k-1.
  - After slot N, go to DRAIN.
- Valid pipe: LAT-deep shift register.
  - Input bit = hy_rd_en, tagged with address k-1.
  - Shifts every cycle that clken=1.
  - Output bit drives hy_wr_en; hy_wr_addr is the tag emerging with it.
- clken: 1 in RUN and DRAIN; 0 in IDLE and DONE.
- DRAIN: stays until the valid pipe is empty and no write is pending, then goes to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Timing (start accepted at edge t):
  - slot k issued at cycle t+1+k;
  - write of cell k-1 at cycle t+1+k+LAT;
  - last write at t+1+N+LAT;
  - done at t+2+N+LAT;
  - busy low from t+3+N+LAT.
- Writes are strictly increasing and contiguous 0..N-1; exactly N writes per sweep.
- Address counters never wrap: N ≤ 2^ADDR_WIDTH-1. Slot index N fits in ADDR_WIDTH bits.
- abort while busy (RUN or DRAIN):
  - next cycle: FSM IDLE, valid pipe cleared, all strobes 0, clken 0;
  - no done pulse;
  - abort in the DONE cycle has no effect (done still pulses).
- start while busy: ignored; no restart, num_cells not re-latched.
- start and abort in the same cycle while IDLE: start accepted.
- RST mid-sweep: same effect as reset; no writes after the reset cycle.
- One-cycle idle gap between back-to-back sweeps: start is accepted in the IDLE cycle following DONE.

Test Plan:
1. Reset, then start with N=4, t=0 → Ez reads addr 0..4 at cycles 1..5; Hy reads addr 0..3 at cycles 2..5; hy_wr_en at cycles 9..12 with addr 0..3; done at cycle 13; busy low at cycle 14; exactly 4 writes.
2. start with N=0 → no rd/wr strobes, clken stays 0, done pulses one cycle after the start cycle.
3. N=3 sweep, abort asserted at cycle 6 (DRAIN, writes outstanding) → from cycle 7 hy_wr_en=0, clken=0, busy=0; no done pulse; a following start with N=2 runs normally with writes to 0,1.
4. start pulsed again at cycles 3 and 8 during an N=4 sweep → ignored; timing identical to scenario 1.
5. N=1023 (ADDR_WIDTH=10) → 1024 Ez reads (0..1023), 1023 Hy reads and writes (0..1022); last write at cycle 1+1023+7=1031; no address wrap.
6. RST asserted at cycle 7 of an N=4 sweep → next cycle all outputs 0; no writes afterwards; start after reset runs a clean sweep.
